// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl
// Miss handler and memory arbiter shared by the I-cache and the D-cache.
// One pending miss is picked, with the D-cache winning a tie. Its block is
// streamed from the pipelined memory port, and each returning word is turned
// into a data write strobe for the cache being served. The tag write is
// issued together with the last data word, so the data and the tag land in
// the same way.
module cache_fill_ctrl #(
   parameter int WORDS = 8,
   parameter int CNT_W = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_miss,
   input  logic [15:0] i_miss_addr,
   input  logic        d_miss,
   input  logic [15:0] d_miss_addr,
   input  logic        mem_data_valid,
   output logic        mem_en,
   output logic [15:0] mem_addr,
   output logic [15:0] fill_addr,
   output logic        i_wr_data,
   output logic        i_wr_tag,
   output logic        d_wr_data,
   output logic        d_wr_tag,
   output logic        busy,
   output logic        serve_d
);

   // Byte offset inside a block: the word index plus the half-word bit.
   localparam int OFS_W = CNT_W + 1;

   // Index of the final word of a block; the tag is written on this word.
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [15:0]      base_q, base_d;
   logic             serve_d_q, serve_d_d;
   logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic             issue_done_q, issue_done_d;

   // The word offset of a faulting address never matters: every fill starts at
   // word 0. These bits are collected here only so they are visibly consumed.
   logic unused_ofs;
   assign unused_ofs = ^{i_miss_addr[OFS_W-1:0], d_miss_addr[OFS_W-1:0]};

   // State register. An asynchronous reset abandons any fill in progress.
   // Words still in flight from memory then arrive in IDLE and are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         base_q       <= '0;
         serve_d_q    <= 1'b0;
         issue_cnt_q  <= '0;
         rx_cnt_q     <= '0;
         issue_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         serve_d_q    <= serve_d_d;
         issue_cnt_q  <= issue_cnt_d;
         rx_cnt_q     <= rx_cnt_d;
         issue_done_q <= issue_done_d;
      end
   end

   // Next-state logic. The base address and the served cache are only latched
   // in IDLE, so misses that change during FILL or DONE cannot disturb a fill.
   // Such a miss is picked up on the next IDLE cycle. The issue side stops
   // after WORDS requests, which the issue_done flag records; a wrapped counter
   // alone could not tell "nothing issued" from "all issued". The receive side
   // ends the fill on the last returned word.
   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      serve_d_d    = serve_d_q;
      issue_cnt_d  = issue_cnt_q;
      rx_cnt_d     = rx_cnt_q;
      issue_done_d = issue_done_q;

      unique case (state_q)
         IDLE: begin
            if (d_miss) begin
               base_d       = {d_miss_addr[15:OFS_W], {OFS_W{1'b0}}};
               serve_d_d    = 1'b1;
               issue_cnt_d  = '0;
               rx_cnt_d     = '0;
               issue_done_d = 1'b0;
               state_d      = FILL;
            end else if (i_miss) begin
               base_d       = {i_miss_addr[15:OFS_W], {OFS_W{1'b0}}};
               serve_d_d    = 1'b0;
               issue_cnt_d  = '0;
               rx_cnt_d     = '0;
               issue_done_d = 1'b0;
               state_d      = FILL;
            end
         end

         FILL: begin
            if (!issue_done_q) begin
               issue_cnt_d = issue_cnt_q + CNT_W'(1);
               if (issue_cnt_q == LAST_WORD) begin
                  issue_done_d = 1'b1;
               end
            end
            if (mem_data_valid) begin
               rx_cnt_d = rx_cnt_q + CNT_W'(1);
               if (rx_cnt_q == LAST_WORD) begin
                  state_d = DONE;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode. Requests and write strobes exist only in FILL. Each write
   // strobe goes to the served cache in the same cycle that its word arrives.
   // The tag strobe is asserted together with the last data strobe.
   always_comb begin
      mem_en    = 1'b0;
      mem_addr  = '0;
      fill_addr = base_q;
      i_wr_data = 1'b0;
      i_wr_tag  = 1'b0;
      d_wr_data = 1'b0;
      d_wr_tag  = 1'b0;
      busy      = (state_q != IDLE);
      serve_d   = serve_d_q;

      if (state_q == FILL) begin
         if (!issue_done_q) begin
            mem_en   = 1'b1;
            mem_addr = {base_q[15:OFS_W], issue_cnt_q, 1'b0};
         end
         if (mem_data_valid) begin
            fill_addr = {base_q[15:OFS_W], rx_cnt_q, 1'b0};
            if (serve_d_q) begin
               d_wr_data = 1'b1;
               d_wr_tag  = (rx_cnt_q == LAST_WORD);
            end else begin
               i_wr_data = 1'b1;
               i_wr_tag  = (rx_cnt_q == LAST_WORD);
            end
         end
      end
   end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl
// Scoreboard bench for cache_fill_ctrl. Starting a miss pushes the expected
// memory requests and cache writes into queues. A monitor pops and compares
// them whenever the controller presents a request or a write strobe. A small
// memory model returns data with a fixed latency of four cycles.
module tb_cache_fill_ctrl;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        iMiss = 1'b0;
   logic [15:0] iMissAddr = '0;
   logic        dMiss = 1'b0;
   logic [15:0] dMissAddr = '0;
   logic        memDataValid = 1'b0;
   logic        memEn;
   logic [15:0] memAddr;
   logic [15:0] fillAddr;
   logic        iWrData, iWrTag, dWrData, dWrTag;
   logic        busy, serveD;

   logic        injectValid = 1'b0;
   logic [3:0]  memPipe = '0;

   int passCount = 0;
   int checkCount = 0;

   typedef struct packed {
      logic        serveD;
      logic [15:0] addr;
      logic        tag;
   } wrExp_t;

   logic [15:0] reqQ[$];
   wrExp_t      wrQ[$];

   cache_fill_ctrl #(.WORDS(8), .CNT_W(3)) dut (
      .clk            (clk),
      .rst_n          (rstN),
      .i_miss         (iMiss),
      .i_miss_addr    (iMissAddr),
      .d_miss         (dMiss),
      .d_miss_addr    (dMissAddr),
      .mem_data_valid (memDataValid),
      .mem_en         (memEn),
      .mem_addr       (memAddr),
      .fill_addr      (fillAddr),
      .i_wr_data      (iWrData),
      .i_wr_tag       (iWrTag),
      .d_wr_data      (dWrData),
      .d_wr_tag       (dWrTag),
      .busy           (busy),
      .serve_d        (serveD)
   );

   always #5 clk = ~clk;

   // Comparison helper shared by the monitor and the directed checks.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic applyStimulus(input logic im, input logic [15:0] ia,
                                input logic dm, input logic [15:0] da);
      iMiss = im;
      iMissAddr = ia;
      dMiss = dm;
      dMissAddr = da;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // The expected traffic for one fill: eight requests from word 0 of the
   // block, then eight writes to the same addresses, with the tag on the last.
   task automatic pushFill(input logic isD, input logic [15:0] addr);
      logic [15:0] base;
      logic [15:0] a;
      wrExp_t w;
      base = {addr[15:4], 4'h0};
      for (int k = 0; k < 8; k++) begin
         a = base + 16'(2 * k);
         reqQ.push_back(a);
         w.serveD = isD;
         w.addr = a;
         w.tag = (k == 7);
         wrQ.push_back(w);
      end
   endtask

   // Waits, with a bound, for the tag strobe of one cache. Returns at the
   // negedge of the cycle that carries the last word.
   task automatic waitTag(input logic isD, input string name);
      bit found;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clk);
         if (isD ? dWrTag : iWrTag) found = 1'b1;
      end
      if (!found) begin
         checkCount++;
         $display("[TB] FAIL %s: tag strobe not seen within 40 cycles, expected one", name);
      end
   endtask

   // Memory model: a request seen in cycle n returns data in cycle n+4.
   // Extra valid pulses can be injected to exercise the idle case.
   initial begin
      logic sample;
      forever begin
         @(negedge clk);
         sample = memEn;
         @(posedge clk);
         #2;
         memPipe = {memPipe[2:0], sample};
         memDataValid = memPipe[3] | injectValid;
      end
   end

   // Monitor: every request and every write strobe must match the next
   // expected entry. A strobe with nothing expected is itself a failure.
   initial begin
      logic [15:0] er;
      wrExp_t ew;
      forever begin
         @(negedge clk);
         if (memEn) begin
            if (reqQ.size() == 0) begin
               checkCount++;
               $display("[TB] FAIL unexpected mem_en: got addr 0x%0h, expected no request", memAddr);
            end else begin
               er = reqQ.pop_front();
               checkOutput("mem_addr", {16'h0, memAddr}, {16'h0, er});
            end
         end
         if (iWrData | iWrTag | dWrData | dWrTag) begin
            if (wrQ.size() == 0) begin
               checkCount++;
               $display("[TB] FAIL unexpected write: got i=%b%b d=%b%b, expected no strobe",
                        iWrData, iWrTag, dWrData, dWrTag);
            end else begin
               ew = wrQ.pop_front();
               checkOutput("write {iData,dData,iTag,dTag,fill_addr}",
                           {12'h0, iWrData, dWrData, iWrTag, dWrTag, fillAddr},
                           {12'h0, !ew.serveD, ew.serveD, ew.tag & !ew.serveD,
                            ew.tag & ew.serveD, ew.addr});
            end
         end
      end
   end

   // Upper bound on the whole run.
   initial begin
      #50000;
      $display("[TB] FAIL watchdog: run did not complete, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence.
   initial begin
      int seen;
      applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
      rstN = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset mem_en", memEn, 0);
      checkOutput("reset serve_d", serveD, 0);
      checkOutput("reset fill_addr", fillAddr, 0);
      checkOutput("reset mem_addr", memAddr, 0);
      nextCycle();
      rstN = 1'b1;
      nextCycle();

      // I miss at 0x1236, held through DONE and released on the IDLE cycle.
      applyStimulus(1'b1, 16'h1236, 1'b0, 16'h0);
      pushFill(1'b0, 16'h1236);
      @(negedge clk);
      checkOutput("t1 busy c0", busy, 0);
      for (int c = 1; c <= 13; c++) begin
         nextCycle();
         @(negedge clk);
         checkOutput($sformatf("t1 mem_en c%0d", c), memEn, (c <= 8) ? 1 : 0);
         checkOutput($sformatf("t1 i_wr_data c%0d", c), iWrData, (c >= 5 && c <= 12) ? 1 : 0);
         checkOutput($sformatf("t1 i_wr_tag c%0d", c), iWrTag, (c == 12) ? 1 : 0);
         checkOutput($sformatf("t1 busy c%0d", c), busy, 1);
      end
      nextCycle();
      applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
      @(negedge clk);
      checkOutput("t1 busy c14", busy, 0);
      nextCycle();
      @(negedge clk);
      checkOutput("t1 busy c15", busy, 0);
      checkOutput("t1 mem_en c15", memEn, 0);

      // Valid pulses while idle must be ignored.
      for (int k = 0; k < 3; k++) begin
         nextCycle();
         injectValid = 1'b1;
         @(negedge clk);
         checkOutput($sformatf("t5 busy %0d", k), busy, 0);
         checkOutput($sformatf("t5 strobes %0d", k),
                     {28'h0, iWrData, iWrTag, dWrData, dWrTag}, 0);
      end
      nextCycle();
      injectValid = 1'b0;

      // Simultaneous misses: D at 0x4008 first, then I at 0x2468.
      nextCycle();
      applyStimulus(1'b1, 16'h2468, 1'b1, 16'h4008);
      pushFill(1'b1, 16'h4008);
      pushFill(1'b0, 16'h2468);
      nextCycle();
      @(negedge clk);
      checkOutput("t2 serve_d on D", serveD, 1);
      checkOutput("t2 first D addr", memAddr, 16'h4000);
      waitTag(1'b1, "t2 D tag");
      nextCycle();
      dMiss = 1'b0;
      @(negedge clk);
      checkOutput("t2 busy D done", busy, 1);
      nextCycle();
      @(negedge clk);
      checkOutput("t2 busy idle", busy, 0);
      nextCycle();
      @(negedge clk);
      checkOutput("t2 serve_d on I", serveD, 0);
      checkOutput("t2 first I addr", memAddr, 16'h2460);
      waitTag(1'b0, "t2 I tag");
      nextCycle();
      iMiss = 1'b0;
      @(negedge clk);
      checkOutput("t2 busy I done", busy, 1);
      nextCycle();
      @(negedge clk);
      checkOutput("t2 busy end", busy, 0);

      // D miss rises during an I fill and waits for it to finish.
      nextCycle();
      applyStimulus(1'b1, 16'h789A, 1'b0, 16'h0);
      pushFill(1'b0, 16'h789A);
      repeat (3) nextCycle();
      dMiss = 1'b1;
      dMissAddr = 16'hABC2;
      pushFill(1'b1, 16'hABC2);
      @(negedge clk);
      checkOutput("t3 serve_d holds I", serveD, 0);
      waitTag(1'b0, "t3 I tag");
      nextCycle();
      iMiss = 1'b0;
      @(negedge clk);
      checkOutput("t3 busy done", busy, 1);
      checkOutput("t3 mem_en done", memEn, 0);
      checkOutput("t3 serve_d done", serveD, 0);
      nextCycle();
      @(negedge clk);
      checkOutput("t3 busy idle", busy, 0);
      nextCycle();
      @(negedge clk);
      checkOutput("t3 D mem_en", memEn, 1);
      checkOutput("t3 D addr", memAddr, 16'hABC0);
      checkOutput("t3 D serve_d", serveD, 1);
      waitTag(1'b1, "t3 D tag");
      nextCycle();
      dMiss = 1'b0;
      nextCycle();
      @(negedge clk);
      checkOutput("t3 busy end", busy, 0);

      // Reset after three words of a D fill; late data must be dropped.
      nextCycle();
      applyStimulus(1'b0, 16'h0, 1'b1, 16'h5554);
      pushFill(1'b1, 16'h5554);
      seen = 0;
      for (int k = 0; k < 40 && seen < 3; k++) begin
         @(negedge clk);
         if (dWrData) seen++;
      end
      checkOutput("t4 words before reset", seen, 3);
      nextCycle();
      rstN = 1'b0;
      dMiss = 1'b0;
      reqQ.delete();
      wrQ.delete();
      #2;
      checkOutput("t4 rst mem_en", memEn, 0);
      checkOutput("t4 rst busy", busy, 0);
      checkOutput("t4 rst d_wr_data", dWrData, 0);
      checkOutput("t4 rst serve_d", serveD, 0);
      checkOutput("t4 rst mem_addr", memAddr, 0);
      checkOutput("t4 rst fill_addr", fillAddr, 0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checkOutput($sformatf("t4 in reset strobes %0d", k),
                     {28'h0, memEn, iWrData, dWrData, dWrTag}, 0);
         nextCycle();
      end
      rstN = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput($sformatf("t4 after reset strobes %0d", k),
                     {28'h0, memEn, iWrData, dWrData, dWrTag}, 0);
         checkOutput($sformatf("t4 after reset busy %0d", k), busy, 0);
         nextCycle();
      end

      checkOutput("request queue drained", reqQ.size(), 0);
      checkOutput("write queue drained", wrQ.size(), 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
